debounce_filter: RTL and testbench

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/debounce_filter_sync_chain.sv | 25 ++
 rtl/debounce_filter.sv | 116 +++++++++++
 tb/tb_debounce_filter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding, defaults and glitch-counter constants for the debounce filter
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } db_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_CNT_WIDTH     = 4;

    localparam int                  GLITCH_WIDTH = 8;
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

    // Saturating increment: a long run of bounces must never make the count wrap to a small value.
    function automatic logic [GLITCH_WIDTH-1:0] glitch_inc(input logic [GLITCH_WIDTH-1:0] value);
        if (value == GLITCH_MAX) begin
            return value;
        end
        return value + GLITCH_WIDTH'(1);
    endfunction

endpackage

// File: rtl/debounce_filter_sync_chain.sv
// rtl/debounce_filter_sync_chain.sv - metastability synchroniser for the raw button input
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else if (SYNC_STAGES == 1) begin
            sync_q <= SYNC_STAGES'(async_in);
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - debounce FSM with registered level, edge pulses and glitch counter
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    btn_in,
    output logic                    btn_level,
    output logic                    btn_rise,
    output logic                    btn_fall,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_in;
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 glitch_hit;
    logic                 level_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(btn_in),
        .sync_out(sync_in)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first differing sample counts as one, so acceptance lands on the STABLE_CYCLES-th sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_hit = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d    = STABLE_LOW;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d    = STABLE_HIGH;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);

    // Outputs are registered from the next state so the level and its pulse appear on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level  <= 1'b0;
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            btn_level <= level_d;
            btn_rise  <= level_d && !btn_level;
            btn_fall  <= !level_d && btn_level;
            if (glitch_hit) begin
                glitch_cnt <= glitch_inc(glitch_cnt);
            end
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// tb/tb_debounce_filter.sv - scoreboard bench for debounce_filter at default parameters
module tb_debounce_filter;

    logic       clk;
    logic       reset_n;
    logic       btn_in;
    logic       btn_level;
    logic       btn_rise;
    logic       btn_fall;
    logic [7:0] glitch_cnt;

    typedef struct {
        bit is_rise;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    debounce_filter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse the DUT presents is matched against the next expected event.
    always @(negedge clk) begin
        if (btn_rise || btn_fall) begin
            ev_t ev;
            n_cmp++;
            if (btn_rise && btn_fall) begin
                n_fail++;
                $display("FAIL both_pulses: rise=%0d fall=%0d at cyc %0d, required never both", btn_rise, btn_fall, cyc);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: rise=%0d fall=%0d at cyc %0d, required no pulse", btn_rise, btn_fall, cyc);
            end else begin
                ev = exp_q.pop_front();
                if (ev.is_rise != btn_rise || ev.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_event: got rise=%0d at cyc %0d, required rise=%0d at cyc %0d",
                             btn_rise, cyc, ev.is_rise, ev.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit is_rise, input int at_cyc);
        ev_t ev;
        ev.is_rise = is_rise;
        ev.cyc     = at_cyc;
        exp_q.push_back(ev);
    endtask

    // Drive a level change at a negedge and verify btn_level flips exactly 10 edges later.
    task automatic change_and_check(input bit val, input string name);
        btn_in = val;
        expect_pulse(val, cyc + 10);
        tick(9);
        check({name, "_before"}, btn_level, int'(!val));
        tick(1);
        check({name, "_after"}, btn_level, int'(val));
    endtask

    initial begin
        reset_n = 1'b0;
        btn_in  = 1'b1;

        tick(2);
        check("reset_level", btn_level, 0);
        check("reset_rise", btn_rise, 0);
        check("reset_fall", btn_fall, 0);
        check("reset_glitch", glitch_cnt, 0);

        // Reset released with btn_in already high
        reset_n = 1'b1;
        expect_pulse(1'b1, cyc + 10);
        tick(9);
        check("rst_rel_before", btn_level, 0);
        tick(1);
        check("rst_rel_after", btn_level, 1);
        tick(5);

        change_and_check(1'b0, "release0");
        tick(5);

        // Clean press held 20 cycles
        change_and_check(1'b1, "press");
        tick(10);
        check("press_level_held", btn_level, 1);
        check("press_glitch", glitch_cnt, 0);
        change_and_check(1'b0, "release1");
        tick(5);

        // Short glitch
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        tick(12);
        check("glitch_level", btn_level, 0);
        check("glitch_cnt1", glitch_cnt, 1);

        // Release bounce: two aborted WAIT_LOW entries, one accepted fall
        change_and_check(1'b1, "press2");
        tick(5);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0;
        expect_pulse(1'b0, cyc + 10);
        tick(15);
        check("bounce_level", btn_level, 0);
        check("bounce_glitch", glitch_cnt, 3);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'b1;
            tick(3);
            btn_in = 1'b0;
            tick(3);
            if (i == 99) begin
                tick(4);
                check("sat_glitch_103", glitch_cnt, 103);
            end
        end
        tick(5);
        check("sat_glitch_255", glitch_cnt, 255);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            tick(3);
            btn_in = 1'b0;
            tick(3);
        end
        tick(5);
        check("sat_glitch_hold", glitch_cnt, 255);
        check("sat_level", btn_level, 0);

        // Mid-press reset: asynchronous clear, then full latency from release
        btn_in = 1'b1;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_glitch", glitch_cnt, 0);
        check("midrst_level", btn_level, 0);
        check("midrst_rise", btn_rise, 0);
        tick(3);
        reset_n = 1'b1;
        expect_pulse(1'b1, cyc + 10);
        tick(9);
        check("midrst_before", btn_level, 0);
        tick(1);
        check("midrst_after", btn_level, 1);
        tick(5);

        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
